// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with base integer ops plus RV32M multiply/divide.
// Latency: 1 edge for base, MUL* and divide corner cases; D_WIDTH+2 edges for a normal divide/remainder.
// Backpressure: InReady drops while a divide iterates or an unconsumed result is held; result holds until OutReady.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   Flush           synchronous abort of the operation in flight (wins over a same-edge accept)
//   InValid/InReady input handshake; InReady is combinational
//   ALUControl      [4]=M-extension, [3]=alt (sub/sra), [2:0]=funct3
//   SrcA, SrcB      operands; shifts use SrcB[SH_W-1:0]
//   OutValid/OutReady output handshake
//   ALUResult, Zero registered result and branch flag
//   Busy            high while the restoring divider iterates
module alu_muldiv #(
    parameter  int D_WIDTH = 32,
    localparam int SH_W    = $clog2(D_WIDTH),
    localparam int CNT_W   = $clog2(D_WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Flush,
    input  logic               InValid,
    output logic               InReady,
    input  logic [4:0]         ALUControl,
    input  logic [D_WIDTH-1:0] SrcA,
    input  logic [D_WIDTH-1:0] SrcB,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [D_WIDTH-1:0] ALUResult,
    output logic               Zero,
    output logic               Busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [D_WIDTH-1:0] MOST_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

    state_t             state_q;
    logic [D_WIDTH-1:0] result_q;
    logic               zero_q;
    logic [D_WIDTH-1:0] quo_q;      // dividend shifts out the top, quotient bits shift in the bottom
    logic [D_WIDTH-1:0] rem_q;
    logic [D_WIDTH-1:0] dvsr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               q_neg_q;
    logic               r_neg_q;
    logic               is_rem_q;
    logic               zero_pend_q; // Zero sampled at accept, published only when the divide finishes

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic accept;

    assign InReady   = (state_q == S_IDLE) || ((state_q == S_DONE) && OutReady);
    assign accept    = InValid && InReady;
    assign OutValid  = (state_q == S_DONE);
    assign Busy      = (state_q == S_DIV);
    assign ALUResult = result_q;
    assign Zero      = zero_q;

    // ------------------------------------------------------------------
    // Op decode
    // ------------------------------------------------------------------
    logic       is_m;
    logic       alt;
    logic [2:0] funct3;

    assign is_m   = ALUControl[4];
    assign alt    = ALUControl[3];
    assign funct3 = ALUControl[2:0];

    // ------------------------------------------------------------------
    // Base integer ops
    // ------------------------------------------------------------------
    logic [D_WIDTH-1:0] base_res;
    logic [SH_W-1:0]    shamt;
    logic               lt_s;
    logic               lt_u;

    assign shamt = SrcB[SH_W-1:0];
    assign lt_s  = $signed(SrcA) < $signed(SrcB);
    assign lt_u  = SrcA < SrcB;

    always_comb begin
        base_res = '0;
        case (funct3)
            3'b000:  base_res = alt ? (SrcA - SrcB) : (SrcA + SrcB);
            3'b001:  base_res = SrcA << shamt;
            3'b010:  base_res = {{(D_WIDTH-1){1'b0}}, lt_s};
            3'b011:  base_res = {{(D_WIDTH-1){1'b0}}, lt_u};
            3'b100:  base_res = SrcA ^ SrcB;
            3'b101:  base_res = alt ? D_WIDTH'($signed(SrcA) >>> shamt) : (SrcA >> shamt);
            3'b110:  base_res = SrcA | SrcB;
            default: base_res = SrcA & SrcB;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply: sign- or zero-extend each operand to 2*D_WIDTH and keep the
    // low 2*D_WIDTH bits of the product; that is the exact two's-complement
    // product for every signedness combination.
    // ------------------------------------------------------------------
    logic                 mul_a_sgn;
    logic                 mul_b_sgn;
    logic [2*D_WIDTH-1:0] mul_a_ext;
    logic [2*D_WIDTH-1:0] mul_b_ext;
    logic [2*D_WIDTH-1:0] prod;
    logic [D_WIDTH-1:0]   mul_res;

    assign mul_a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010);
    assign mul_b_sgn = (funct3 == 3'b001);
    assign mul_a_ext = {{D_WIDTH{mul_a_sgn & SrcA[D_WIDTH-1]}}, SrcA};
    assign mul_b_ext = {{D_WIDTH{mul_b_sgn & SrcB[D_WIDTH-1]}}, SrcB};
    assign prod      = mul_a_ext * mul_b_ext;
    assign mul_res   = (funct3 == 3'b000) ? prod[D_WIDTH-1:0] : prod[2*D_WIDTH-1:D_WIDTH];

    // ------------------------------------------------------------------
    // Divide setup and single-cycle corner cases
    // ------------------------------------------------------------------
    logic               div_signed;
    logic               div_is_rem;
    logic               a_neg;
    logic               b_neg;
    logic [D_WIDTH-1:0] a_mag;
    logic [D_WIDTH-1:0] b_mag;
    logic               div_by_zero;
    logic               div_ovf;
    logic [D_WIDTH-1:0] div_fast_res;
    logic               go_div;

    assign div_signed  = ~funct3[0];
    assign div_is_rem  = funct3[1];
    assign a_neg       = div_signed & SrcA[D_WIDTH-1];
    assign b_neg       = div_signed & SrcB[D_WIDTH-1];
    assign a_mag       = a_neg ? -SrcA : SrcA;
    assign b_mag       = b_neg ? -SrcB : SrcB;
    assign div_by_zero = (SrcB == '0);
    assign div_ovf     = div_signed && (SrcA == MOST_NEG) && (SrcB == '1);
    assign go_div      = is_m && funct3[2] && !div_by_zero && !div_ovf;

    always_comb begin
        div_fast_res = '0;
        if (div_by_zero) begin
            div_fast_res = div_is_rem ? SrcA : '1;
        end else begin
            div_fast_res = div_is_rem ? '0 : SrcA;
        end
    end

    // Result and Zero for everything that finishes on the accept edge
    logic [D_WIDTH-1:0] imm_res;
    logic               zero_in;

    always_comb begin
        imm_res = base_res;
        if (is_m) begin
            imm_res = funct3[2] ? div_fast_res : mul_res;
        end
    end

    // Only the base SLT/SLTU ops report the comparison; everything else reports A==B
    assign zero_in = (!is_m && (funct3[2:1] == 2'b01)) ? base_res[0] : (SrcA == SrcB);

    // ------------------------------------------------------------------
    // Restoring divide step. rem_q < dvsr_q always holds, so the shifted
    // partial remainder is below 2*dvsr_q and the difference fits D_WIDTH bits.
    // ------------------------------------------------------------------
    logic [D_WIDTH:0]   rem_sh;
    logic [D_WIDTH:0]   rem_diff;
    logic               step_ge;
    logic [D_WIDTH-1:0] rem_step;
    logic [D_WIDTH-1:0] quo_step;

    assign rem_sh   = {rem_q, quo_q[D_WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, dvsr_q};
    assign step_ge  = ~rem_diff[D_WIDTH];
    assign rem_step = step_ge ? rem_diff[D_WIDTH-1:0] : rem_sh[D_WIDTH-1:0];
    assign quo_step = {quo_q[D_WIDTH-2:0], step_ge};

    logic [D_WIDTH-1:0] quo_fix;
    logic [D_WIDTH-1:0] rem_fix;

    assign quo_fix = q_neg_q ? -quo_q : quo_q;
    assign rem_fix = r_neg_q ? -rem_q : rem_q;

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            is_rem_q    <= 1'b0;
            zero_pend_q <= 1'b0;
        end else if (Flush) begin
            // Abort: drop whatever is in flight, leave the last result visible on ALUResult
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (go_div) begin
                            state_q     <= S_DIV;
                            quo_q       <= a_mag;
                            rem_q       <= '0;
                            dvsr_q      <= b_mag;
                            cnt_q       <= '0;
                            q_neg_q     <= a_neg ^ b_neg;
                            r_neg_q     <= a_neg;
                            is_rem_q    <= div_is_rem;
                            zero_pend_q <= zero_in;
                        end else begin
                            state_q  <= S_DONE;
                            result_q <= imm_res;
                            zero_q   <= zero_in;
                        end
                    end else if (state_q == S_DONE && OutReady) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DIV: begin
                    quo_q <= quo_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(D_WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                default: begin // S_FIX
                    result_q <= is_rem_q ? rem_fix : quo_fix;
                    zero_q   <= zero_pend_q;
                    state_q  <= S_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

    logic        clk;
    logic        rst;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [4:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Busy;

    int n_cmp;
    int n_err;

    alu_muldiv #(.D_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .Flush      (Flush),
        .InValid    (InValid),
        .InReady    (InReady),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    // Present one op at the negedge; return #1 after the edge it is sampled on.
    task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUControl = c;
        SrcA       = a;
        SrcB       = b;
        InValid    = 1'b1;
        @(posedge clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (OutValid !== 1'b0 || Busy !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0 || InReady !== 1'b1) begin
            n_err++;
            $display("FAIL reset: OutValid=%b Busy=%b ALUResult=%h Zero=%b InReady=%b, required 0 0 00000000 0 1",
                     OutValid, Busy, ALUResult, Zero, InReady);
        end
    endtask

    // Single-cycle ops issued back-to-back; each result must be visible right after its accept edge.
    task automatic test_single_cycle();
        vec_t v[16];
        v[0]  = '{"add_ovf",    5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
        v[1]  = '{"sub_eq",     5'b01000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
        v[2]  = '{"sra",        5'b01101, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
        v[3]  = '{"slt",        5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1};
        v[4]  = '{"sltu",       5'b00011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        v[5]  = '{"sll",        5'b00001, 32'h00000003, 32'h0000003F, 32'h80000000, 1'b0};
        v[6]  = '{"srl",        5'b00101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
        v[7]  = '{"xor",        5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
        v[8]  = '{"mulh",       5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        v[9]  = '{"mulhu",      5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
        v[10] = '{"mul",        5'b10000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        v[11] = '{"mulhsu",     5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0};
        v[12] = '{"div_by0",    5'b10100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        v[13] = '{"remu_by0",   5'b10111, 32'h00000005, 32'h00000000, 32'h00000005, 1'b0};
        v[14] = '{"div_ovf",    5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        v[15] = '{"rem_ovf",    5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        OutReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(v[i].ctrl, v[i].a, v[i].b);
            n_cmp++;
            if (OutValid !== 1'b1 || ALUResult !== v[i].res || Zero !== v[i].zero) begin
                n_err++;
                $display("FAIL %s: OutValid=%b ALUResult=%h Zero=%b, required 1 %h %b",
                         v[i].name, OutValid, ALUResult, Zero, v[i].res, v[i].zero);
            end
        end
    endtask

    // Iterative divides: result must appear exactly 34 edges after accept (accept edge = 1),
    // with Busy high for 32 sampled cycles and no early OutValid.
    task automatic test_divide();
        vec_t v[4];
        int   ov_edge;
        int   busy_cnt;
        v[0] = '{"div_neg",  5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
        v[1] = '{"rem_neg",  5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
        v[2] = '{"divu",     5'b10101, 32'd100,      32'd7,        32'd14,       1'b0};
        v[3] = '{"remu",     5'b10111, 32'd100,      32'd7,        32'd2,        1'b0};
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(v[i].ctrl, v[i].a, v[i].b);
            ov_edge  = 0;
            busy_cnt = Busy ? 1 : 0;
            if (OutValid === 1'b1) ov_edge = 1;
            for (int k = 2; k <= 60 && ov_edge == 0; k++) begin
                @(posedge clk);
                #1;
                if (OutValid === 1'b1) begin
                    ov_edge = k;
                end else if (Busy === 1'b1) begin
                    busy_cnt++;
                end
            end
            n_cmp++;
            if (ov_edge != 34 || busy_cnt != 32) begin
                n_err++;
                $display("FAIL %s_timing: OutValid at edge %0d Busy cycles %0d, required 34 and 32",
                         v[i].name, ov_edge, busy_cnt);
            end
            n_cmp++;
            if (ALUResult !== v[i].res || Zero !== v[i].zero) begin
                n_err++;
                $display("FAIL %s: ALUResult=%h Zero=%b, required %h %b",
                         v[i].name, ALUResult, Zero, v[i].res, v[i].zero);
            end
        end
    endtask

    // Stalled consumer, then back-to-back accept on the release edge.
    task automatic test_back_to_back();
        int bad;
        @(negedge clk);
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(posedge clk);
        #1;
        OutReady = 1'b0;
        issue(5'b00000, 32'd3, 32'd4);
        n_cmp++;
        if (OutValid !== 1'b1 || ALUResult !== 32'd7) begin
            n_err++;
            $display("FAIL hold_first: OutValid=%b ALUResult=%h, required 1 00000007", OutValid, ALUResult);
        end
        // Junk presented while stalled must be ignored.
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            InValid    = 1'b1;
            ALUControl = 5'b00000;
            SrcA       = 32'h1000 + 32'(c);
            SrcB       = 32'h2000;
            @(posedge clk);
            #1;
            if (ALUResult !== 32'd7 || InReady !== 1'b0 || OutValid !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_stable: %0d of 5 cycles unstable, required 0", bad);
        end
        @(negedge clk);
        OutReady   = 1'b1;
        ALUControl = 5'b00000;
        SrcA       = 32'd10;
        SrcB       = 32'd20;
        InValid    = 1'b1;
        #1;
        n_cmp++;
        if (InReady !== 1'b1) begin
            n_err++;
            $display("FAIL release_inready: InReady=%b, required 1", InReady);
        end
        @(posedge clk);
        #1;
        InValid = 1'b0;
        n_cmp++;
        if (OutValid !== 1'b1 || ALUResult !== 32'd30) begin
            n_err++;
            $display("FAIL release_result: OutValid=%b ALUResult=%h, required 1 0000001e", OutValid, ALUResult);
        end
    endtask

    // Flush at iteration 10 of a divide, with a simultaneous op that must be refused.
    task automatic test_flush();
        int rose;
        OutReady = 1'b1;
        issue(5'b10100, 32'd100, 32'd7);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        Flush      = 1'b1;
        InValid    = 1'b1;
        ALUControl = 5'b00000;
        SrcA       = 32'd1;
        SrcB       = 32'd1;
        @(posedge clk);
        #1;
        Flush   = 1'b0;
        InValid = 1'b0;
        n_cmp++;
        if (OutValid !== 1'b0 || Busy !== 1'b0 || InReady !== 1'b1) begin
            n_err++;
            $display("FAIL flush_idle: OutValid=%b Busy=%b InReady=%b, required 0 0 1", OutValid, Busy, InReady);
        end
        rose = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (OutValid !== 1'b0 || Busy !== 1'b0) rose++;
        end
        n_cmp++;
        if (rose != 0 || ALUResult !== 32'd30) begin
            n_err++;
            $display("FAIL flush_quiet: %0d active cycles ALUResult=%h, required 0 and 0000001e", rose, ALUResult);
        end
    endtask

    // Asynchronous reset in the middle of a divide, then a clean divide.
    task automatic test_reset_mid_divide();
        int waited;
        OutReady = 1'b1;
        issue(5'b10101, 32'd100, 32'd7);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (OutValid !== 1'b0 || Busy !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: OutValid=%b Busy=%b ALUResult=%h Zero=%b, required 0 0 00000000 0",
                     OutValid, Busy, ALUResult, Zero);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(5'b10101, 32'd9, 32'd3);
        waited = 0;
        while (OutValid !== 1'b1 && waited < 60) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_cmp++;
        if (OutValid !== 1'b1 || ALUResult !== 32'd3) begin
            n_err++;
            $display("FAIL divu_after_rst: OutValid=%b ALUResult=%h, required 1 00000003", OutValid, ALUResult);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        Flush      = 1'b0;
        InValid    = 1'b0;
        OutReady   = 1'b1;
        ALUControl = 5'b0;
        SrcA       = 32'h0;
        SrcB       = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_single_cycle();
        test_divide();
        test_back_to_back();
        test_flush();
        test_reset_mid_divide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
